vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock produced by the
//  VGA PLL. Consumes the PLL's outclk_0 as clk and its locked flag. Drives hsync/vsync/blank
//  to the DAC/connector and pixel coordinates to downstream pixel-colour logic.
//  Raster runs only while the PLL reports lock.
// PARAMETERS
//  H_VISIBLE  640  active pixels per line
//  H_FRONT    16   horizontal front porch, clk cycles
//  H_SYNC     96   hsync pulse width, clk cycles
//  H_BACK     48   horizontal back porch, clk cycles
//  V_VISIBLE  480  active lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vsync pulse width, lines
//  V_BACK     33   vertical back porch, lines
//  CNT_W      10   width of counters and coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1      pixel clock, 25 MHz, from PLL outclk_0
//  rst          in   1      asynchronous active-high reset
//  pll_locked   in   1      PLL locked flag; asynchronous to clk, synchronized internally
//  hsync_n      out  1      horizontal sync, active low
//  vsync_n      out  1      vertical sync, active low
//  blank_n      out  1      low outside the visible area; same value as video_on
//  video_on     out  1      high while the current pixel is visible
//  pixel_x      out  CNT_W  current column, 0..H_TOTAL-1
//  pixel_y      out  CNT_W  current line, 0..V_TOTAL-1
//  frame_start  out  1      one-cycle pulse when (pixel_x,pixel_y) == (0,0)
//  line_end     out  1      one-cycle pulse when pixel_x == H_TOTAL-1
// BEHAVIOUR
//  - Derived totals: H_TOTAL = sum of H_*, which is 800. V_TOTAL = sum of V_*, which is 525.
//  - Lock synchronizer: 2-FF chain on pll_locked. Output run = second flop. Both flops reset to 0.
//  - Counters h_cnt and v_cnt:
//    - While run=0, h_cnt and v_cnt are held at 0.
//    - While run=1, h_cnt increments each clk. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt advances.
//    - v_cnt wraps to 0 after V_TOTAL-1. Both counters wrap on the same edge at (799,524).
//  - Output register stage:
//    - All outputs are registered from (h_cnt,v_cnt) on the same edge, so they are mutually aligned.
//    - Latency is 1 clk from counter to outputs.
//    - When run=0, the output stage loads its reset values.
//  - Decode, evaluated on the counter values:
//    - hsync_n = 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
//    - vsync_n = 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
//      vsync_n changes only when h_cnt=0.
//    - video_on = blank_n = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
//  - Reset values of all outputs: hsync_n=1, vsync_n=1, blank_n=0, video_on=0, pixel_x=0,
//    pixel_y=0, frame_start=0, line_end=0.
//  - rst is asynchronous: all flops clear immediately on rst assertion, with no clk edge needed.
//  - Start-up: rst deasserted while pll_locked=1 gives this sequence:
//    - edge 1: sync flop 1 = 1
//    - edge 2: run = 1
//    - edge 3: outputs show (0,0) with frame_start=1
//    - Counting proceeds continuously from then on.
//  - Lock loss mid-frame:
//    - run falls 2 edges after pll_locked falls.
//    - On the next edge the counters return to 0 and the outputs take their reset values.
//    - No partial sync pulse is stretched.
//    - On relock, the raster restarts at (0,0) with frame_start, using the same 3-edge sequence.
//  - pll_locked glitches shorter than 1 clk may be missed; no other filtering is applied.
// TESTING
//  T1 start-up: rst 1->0 with pll_locked=1
//     -> frame_start=1 and pixel_x=pixel_y=0 on the 3rd rising edge after rst deasserts.
//     -> Thereafter frame_start pulses every 420000 clks.
//  T2 hsync: one line
//     -> hsync_n low for exactly 96 clks, starting on the cycle where pixel_x=656.
//     -> line_end at pixel_x=799. Period 800 clks.
//  T3 vsync: one frame
//     -> vsync_n low for exactly 1600 clks, starting where pixel_y=490 and pixel_x=0.
//  T4 visible count: one full frame -> video_on high on exactly 307200 clks.
//     -> blank_n == video_on every cycle. No video_on when pixel_x>=640 or pixel_y>=480.
//  T5 lock loss: drop pll_locked at pixel (300,200)
//     -> 3 edges later all outputs at reset values.
//     -> Reassert pll_locked -> frame_start at (0,0) 3 edges after reassertion.
//  T6 async reset: assert rst between clk edges mid-line
//     -> outputs at reset values before the next edge.
//     -> Release rst -> same sequence as T1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters gated by a synchronized PLL lock,
// with all sync, blanking and coordinate outputs registered on a common edge.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             blank_n,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start,
  output logic             line_end
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_LO  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_HI  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_LO  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_HI  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  // Half-open range test [lo, hi) used by the sync decoders.
  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

  logic             sync1_r;
  logic             run_r;
  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;
  logic [CNT_W-1:0] h_nxt_s;
  logic [CNT_W-1:0] v_nxt_s;
  logic             hsync_n_s;
  logic             vsync_n_s;
  logic             video_on_s;
  logic             frame_start_s;
  logic             line_end_s;

  // Two-flop synchronizer bringing the PLL lock flag into the pixel clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      run_r   <= 1'b0;
    end else begin
      sync1_r <= pll_locked;
      run_r   <= sync1_r;
    end
  end

  // Next raster position; held at the origin whenever the lock is not established.
  always_comb begin
    h_nxt_s = CNT_ZERO;
    v_nxt_s = CNT_ZERO;
    if (!run_r) begin
      h_nxt_s = CNT_ZERO;
      v_nxt_s = CNT_ZERO;
    end else if (h_cnt_r == H_LAST) begin
      h_nxt_s = CNT_ZERO;
      if (v_cnt_r == V_LAST) begin
        v_nxt_s = CNT_ZERO;
      end else begin
        v_nxt_s = v_cnt_r + CNT_ONE;
      end
    end else begin
      h_nxt_s = h_cnt_r + CNT_ONE;
      v_nxt_s = v_cnt_r;
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= CNT_ZERO;
      v_cnt_r <= CNT_ZERO;
    end else begin
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
    end
  end

  // Timing decode of the current counter values; v_cnt only moves when h_cnt wraps,
  // so vsync edges naturally fall on h_cnt == 0.
  always_comb begin
    hsync_n_s     = ~in_range(h_cnt_r, H_SYNC_LO, H_SYNC_HI);
    vsync_n_s     = ~in_range(v_cnt_r, V_SYNC_LO, V_SYNC_HI);
    video_on_s    = (h_cnt_r < H_VIS_END) && (v_cnt_r < V_VIS_END);
    frame_start_s = (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
    line_end_s    = (h_cnt_r == H_LAST);
  end

  // Output register stage: one clock behind the counters, idle values while not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      blank_n     <= 1'b0;
      video_on    <= 1'b0;
      pixel_x     <= CNT_ZERO;
      pixel_y     <= CNT_ZERO;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else if (!run_r) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      blank_n     <= 1'b0;
      video_on    <= 1'b0;
      pixel_x     <= CNT_ZERO;
      pixel_y     <= CNT_ZERO;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else begin
      hsync_n     <= hsync_n_s;
      vsync_n     <= vsync_n_s;
      blank_n     <= video_on_s;
      video_on    <= video_on_s;
      pixel_x     <= h_cnt_r;
      pixel_y     <= v_cnt_r;
      frame_start <= frame_start_s;
      line_end    <= line_end_s;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster: a per-cycle reference derived from
// the elapsed raster index, plus whole-frame tallies and directed lock/reset scenarios.
module tb_vga_timing_gen;

  localparam int HV = 40;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 6;
  localparam int VV = 30;
  localparam int VF = 3;
  localparam int VS = 2;
  localparam int VB = 5;
  localparam int CW = 10;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          hsync_n;
  logic          vsync_n;
  logic          blank_n;
  logic          video_on;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          frame_start;
  logic          line_end;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: lock samples seen at the last two edges, and how many consecutive
  // edges the raster has been running.
  bit lock_d1 = 1'b0;
  bit lock_d2 = 1'b0;
  int streak  = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .line_end(line_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    lock_d1 = 1'b0;
    lock_d2 = 1'b0;
    streak  = 0;
  endtask

  // Compare every output against the raster position implied by the run streak.
  task automatic check_all();
    int idx, x, y;
    bit run;
    run = (streak > 0);
    idx = streak - 1;
    x = run ? idx % HT : 0;
    y = run ? (idx / HT) % VT : 0;
    chk("pixel_x", int'(pixel_x), x);
    chk("pixel_y", int'(pixel_y), y);
    chk("hsync_n", int'(hsync_n), (run && x >= HV + HF && x < HV + HF + HS) ? 0 : 1);
    chk("vsync_n", int'(vsync_n), (run && y >= VV + VF && y < VV + VF + VS) ? 0 : 1);
    chk("video_on", int'(video_on), (run && x < HV && y < VV) ? 1 : 0);
    chk("blank_n", int'(blank_n), (run && x < HV && y < VV) ? 1 : 0);
    chk("frame_start", int'(frame_start), (run && x == 0 && y == 0) ? 1 : 0);
    chk("line_end", int'(line_end), (run && x == HT - 1) ? 1 : 0);
  endtask

  // Advance one clock: run is the lock flag seen two edges earlier.
  task automatic step();
    bit run_now;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      run_now = lock_d2;
      lock_d2 = lock_d1;
      lock_d1 = pll_locked;
      streak  = run_now ? streak + 1 : 0;
    end
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_hs"}, int'(hsync_n), 1);
    chk({tag, "_vs"}, int'(vsync_n), 1);
    chk({tag, "_bl"}, int'(blank_n), 0);
    chk({tag, "_vid"}, int'(video_on), 0);
    chk({tag, "_px"}, int'(pixel_x), 0);
    chk({tag, "_py"}, int'(pixel_y), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_le"}, int'(line_end), 0);
  endtask

  initial begin
    int n_vid, n_hs, n_vs, n_le, n_fs, hold, gap;

    // Reset with the PLL already locked.
    rst = 1'b1;
    pll_locked = 1'b1;
    steps(3);
    check_idle("reset");

    // Start-up: origin with frame_start on the third edge after release.
    rst = 1'b0;
    steps(2);
    chk("t1_pre_fs", int'(frame_start), 0);
    step();
    chk("t1_fs", int'(frame_start), 1);
    chk("t1_px", int'(pixel_x), 0);
    chk("t1_py", int'(pixel_y), 0);

    // One full frame of tallies, independent of the per-cycle reference.
    n_vid = 0; n_hs = 0; n_vs = 0; n_le = 0; n_fs = 0;
    for (int i = 0; i < FR; i++) begin
      n_vid += int'(video_on);
      n_hs  += int'(!hsync_n);
      n_vs  += int'(!vsync_n);
      n_le  += int'(line_end);
      n_fs  += int'(frame_start);
      step();
    end
    chk("frame_video_count", n_vid, HV * VV);
    chk("frame_hsync_low", n_hs, HS * VT);
    chk("frame_vsync_low", n_vs, VS * HT);
    chk("frame_line_ends", n_le, VT);
    chk("frame_fs_count", n_fs, 1);
    chk("frame_period_fs", int'(frame_start), 1);

    // Random lock drops with random dwell times.
    for (int k = 0; k < 5; k++) begin
      steps(int'($urandom_range(50, 2 * FR)));
      pll_locked = 1'b0;
      steps(2);
      step();
      check_idle("t5_lost");
      gap = int'($urandom_range(0, 6));
      steps(gap);
      pll_locked = 1'b1;
      steps(2);
      chk("t5_relock_pre_fs", int'(frame_start), 0);
      step();
      chk("t5_relock_fs", int'(frame_start), 1);
      chk("t5_relock_px", int'(pixel_x), 0);
      chk("t5_relock_py", int'(pixel_y), 0);
    end

    // Asynchronous reset between edges, mid-line.
    for (int k = 0; k < 2; k++) begin
      hold = int'($urandom_range(HV + 1, FR));
      steps(hold);
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      check_idle("t6_async");
      steps(2);
      check_idle("t6_held");
      rst = 1'b0;
      steps(2);
      chk("t6_pre_fs", int'(frame_start), 0);
      step();
      chk("t6_fs", int'(frame_start), 1);
      steps(int'($urandom_range(HT, 3 * HT)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
